irq_controller: RTL and testbench

- Memory-mapped interrupt controller that shares the single CPU interrupt input among up to N_SRC device interrupt sources (buttons, timers, UART, ...).
- Captures a rising edge on each source into a pending register and applies a per-source mask.
- Selects the highest-priority pending source, holds the CPU interrupt until software signals end-of-interrupt (EOI), then re-arbitrates.
- Sits on the peripheral bus beside the other devices, using the same addr/write_enable/write_data/read_result bus interface.

---
 rtl/irq_ctrl_pkg.sv | 11 +
 rtl/irq_controller_if.sv | 10 +
 rtl/irq_priority_encoder.sv | 16 +
 rtl/irq_controller.sv | 108 ++++++++++
 tb/tb_irq_controller.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: register offsets and FSM encoding.
package irq_ctrl_pkg;
  localparam logic [1:0] REG_PENDING = 2'd0;
  localparam logic [1:0] REG_MASK    = 2'd1;
  localparam logic [1:0] REG_ACTIVE  = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SERVICE = 2'd1;
  localparam logic [1:0] S_GAP     = 2'd2;
endpackage

// File: rtl/irq_controller_if.sv
// Peripheral bus port shared by all memory-mapped devices.
interface irq_controller_if;
  logic [31:0] addr;
  logic        write_enable;
  logic [31:0] write_data;
  logic [31:0] read_result;

  modport master (output addr, output write_enable, output write_data, input read_result);
  modport slave  (input addr, input write_enable, input write_data, output read_result);
endinterface

// File: rtl/irq_priority_encoder.sv
// Combinational lowest-index-wins encoder; index 0 is the highest priority.
module irq_priority_encoder #(
  parameter int N_SRC = 6
) (
  input  logic [N_SRC-1:0] req,
  output logic             valid,
  output logic [4:0]       idx
);
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) idx = 5'(i);
    end
  end
endmodule

// File: rtl/irq_controller.sv
// Edge-capturing interrupt controller: pending/mask registers, fixed priority,
// hold-until-EOI servicing with a mandatory low cycle between interrupts.
module irq_controller
  import irq_ctrl_pkg::*;
#(
  parameter int N_SRC = 6
) (
  input  logic              clk,
  input  logic              rst,
  irq_controller_if.slave   bus,
  input  logic [N_SRC-1:0]  src_irq,
  output logic              cpu_irq,
  output logic [4:0]        active_id
);
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] src_prev_q, src_prev_d;
  logic [1:0]       state_q, state_d;
  logic [4:0]       active_id_q, active_id_d;
  logic             cpu_irq_q, cpu_irq_d;

  logic [1:0]       sel;
  logic             eoi;
  logic [N_SRC-1:0] rise, w1c, claim;
  logic             pe_valid;
  logic [4:0]       pe_idx;
  logic             unused_bus;

  assign sel        = bus.addr[3:2];
  assign eoi        = bus.write_enable && (sel == REG_ACTIVE);
  assign rise       = src_irq & ~src_prev_q;
  assign w1c        = (bus.write_enable && (sel == REG_PENDING)) ? bus.write_data[N_SRC-1:0] : '0;
  assign unused_bus = ^{bus.addr[31:4], bus.addr[1:0], bus.write_data};

  irq_priority_encoder #(.N_SRC(N_SRC)) u_pe (
    .req   (pending_q & mask_q),
    .valid (pe_valid),
    .idx   (pe_idx)
  );

  always_comb begin
    state_d     = state_q;
    active_id_d = active_id_q;
    cpu_irq_d   = cpu_irq_q;
    claim       = '0;
    case (state_q)
      S_IDLE: begin
        if (pe_valid) begin
          for (int i = 0; i < N_SRC; i++) claim[i] = (pe_idx == 5'(i));
          active_id_d = pe_idx + 5'd1;
          cpu_irq_d   = 1'b1;
          state_d     = S_SERVICE;
        end
      end
      S_SERVICE: begin
        // No preemption: only EOI leaves service.
        if (eoi) begin
          active_id_d = '0;
          cpu_irq_d   = 1'b0;
          state_d     = S_GAP;
        end
      end
      default: begin
        active_id_d = '0;
        cpu_irq_d   = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // A new edge beats both software clear and the claim in the same cycle.
  always_comb begin
    src_prev_d = src_irq;
    pending_d  = (pending_q & ~(w1c | claim)) | rise;
    mask_d     = (bus.write_enable && (sel == REG_MASK)) ? bus.write_data[N_SRC-1:0] : mask_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= '0;
      mask_q      <= '0;
      src_prev_q  <= '0;
      state_q     <= S_IDLE;
      active_id_q <= '0;
      cpu_irq_q   <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      src_prev_q  <= src_prev_d;
      state_q     <= state_d;
      active_id_q <= active_id_d;
      cpu_irq_q   <= cpu_irq_d;
    end
  end

  always_comb begin
    bus.read_result = '0;
    case (sel)
      REG_PENDING: bus.read_result[N_SRC-1:0] = pending_q;
      REG_MASK:    bus.read_result[N_SRC-1:0] = mask_q;
      REG_ACTIVE:  bus.read_result[4:0]       = active_id_q;
      default:     bus.read_result[3:0]       = {state_q, cpu_irq_q, |(pending_q & mask_q)};
    endcase
  end

  assign cpu_irq   = cpu_irq_q;
  assign active_id = active_id_q;
endmodule

// File: tb/tb_irq_controller.sv
// Directed scoreboard bench for irq_controller: stimulus queues expectations
// tagged with a cycle number; a negedge monitor pops and compares them.
module tb_irq_controller;
  import irq_ctrl_pkg::*;

  localparam int N_SRC = 6;
  localparam int K_CPU = 0, K_ACT = 1, K_RD = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_SRC-1:0] src_irq;
  logic             cpu_irq;
  logic [4:0]       active_id;
  int               cyc = 0;
  int               vectors = 0;
  int               miscompares = 0;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;
  exp_t q[$];

  irq_controller_if bus();

  irq_controller #(.N_SRC(N_SRC)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .src_irq   (src_irq),
    .cpu_irq   (cpu_irq),
    .active_id (active_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      case (e.kind)
        K_CPU:   act = {31'b0, cpu_irq};
        K_ACT:   act = {27'b0, active_id};
        default: act = bus.read_result;
      endcase
      vectors++;
      if (e.cyc != cyc || act !== e.exp) begin
        miscompares++;
        $display("FAIL %s: got %0h expected %0h (cycle %0d, due %0d)", e.name, act, e.exp, cyc, e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int kind, input logic [31:0] exp, input string name);
    exp_t e;
    e.cyc = cyc; e.kind = kind; e.exp = exp; e.name = name;
    q.push_back(e);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    bus.addr = {28'b0, a, 2'b00};
    chk(K_RD, exp, name);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.addr         = {28'b0, a, 2'b00};
    bus.write_data   = d;
    bus.write_enable = 1'b1;
    tick();
    bus.write_enable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; src_irq = '0;
    bus.addr = '0; bus.write_data = '0; bus.write_enable = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk(K_CPU, 0, "rst_cpu"); chk(K_ACT, 0, "rst_active");
    rd(REG_PENDING, 0, "rst_pending"); tick();
    rd(REG_MASK, 0, "rst_mask"); tick();
    rd(REG_ACTIVE, 0, "rst_active_reg"); tick();
    rd(REG_STATUS, 0, "rst_status"); tick();
    wr(REG_MASK, 32'hFFFF_FFFF);
    rd(REG_MASK, 32'h3F, "mask_upper_bits"); tick();

    // Single source, latency and EOI
    src_irq = 6'h04; tick(); src_irq = '0;
    rd(REG_PENDING, 32'h4, "t1_pending"); chk(K_CPU, 0, "t1_cpu_pre"); tick();
    chk(K_CPU, 1, "t1_cpu"); rd(REG_ACTIVE, 3, "t1_active"); tick();
    rd(REG_PENDING, 0, "t1_pending_claimed"); tick();
    rd(REG_STATUS, 32'h6, "t1_status_service"); tick();
    wr(REG_ACTIVE, 0);
    chk(K_CPU, 0, "t1_eoi_cpu"); chk(K_ACT, 0, "t1_eoi_active");
    rd(REG_STATUS, 32'h8, "t1_status_gap"); tick(); tick();
    chk(K_CPU, 0, "t1_idle_cpu");

    // Simultaneous rises: priority, then back-to-back after EOI
    src_irq = 6'h12; tick(); src_irq = '0; tick();
    chk(K_CPU, 1, "t2_cpu"); chk(K_ACT, 2, "t2_active");
    wr(REG_ACTIVE, 0);
    chk(K_CPU, 0, "t2_gap_cpu"); chk(K_ACT, 0, "t2_gap_active"); tick();
    chk(K_CPU, 0, "t2_idle_cpu"); tick();
    chk(K_CPU, 1, "t2_cpu_next"); chk(K_ACT, 5, "t2_active_next");
    wr(REG_ACTIVE, 0); tick(); tick();
    chk(K_CPU, 0, "t2_done");

    // Masked source latches but does not interrupt
    wr(REG_MASK, 0);
    src_irq = 6'h01; tick(); src_irq = '0;
    rd(REG_PENDING, 32'h1, "t3_pending"); tick(); tick();
    chk(K_CPU, 0, "t3_masked_cpu"); rd(REG_STATUS, 0, "t3_status"); tick();
    wr(REG_MASK, 1);
    chk(K_CPU, 0, "t3_cpu_after_mask_wr"); tick();
    chk(K_CPU, 1, "t3_cpu"); chk(K_ACT, 1, "t3_active");
    wr(REG_ACTIVE, 0); tick(); tick();

    // Set wins over W1C; plain W1C clears
    wr(REG_MASK, 0);
    bus.addr = {28'b0, REG_PENDING, 2'b00}; bus.write_data = 32'h8;
    bus.write_enable = 1'b1; src_irq = 6'h08;
    tick();
    bus.write_enable = 1'b0; src_irq = '0;
    rd(REG_PENDING, 32'h8, "t4_set_wins"); tick();
    wr(REG_PENDING, 32'h8);
    rd(REG_PENDING, 0, "t4_w1c"); chk(K_CPU, 0, "t4_cpu"); tick();

    // No preemption, mask change in service, re-edge and held-high source
    wr(REG_MASK, 32'h3F);
    src_irq = 6'h08; tick(); src_irq = '0; tick();
    chk(K_ACT, 4, "t5_active");
    wr(REG_MASK, 0);
    chk(K_CPU, 1, "t5_mask_clr_cpu"); chk(K_ACT, 4, "t5_mask_clr_active");
    wr(REG_MASK, 32'h3F);
    src_irq = 6'h01; tick(); src_irq = '0; tick(); tick();
    chk(K_ACT, 4, "t5_no_preempt"); rd(REG_PENDING, 32'h1, "t5_pending0"); tick();
    src_irq = 6'h08; tick(); tick(); tick();
    rd(REG_PENDING, 32'h9, "t5_reedge"); tick();
    wr(REG_ACTIVE, 0);
    chk(K_CPU, 0, "t5_eoi_cpu"); tick(); tick();
    chk(K_ACT, 1, "t5_active_after_gap"); rd(REG_PENDING, 32'h8, "t5_held_single"); tick();
    wr(REG_ACTIVE, 0); tick(); tick();
    chk(K_ACT, 4, "t5_active_reedge"); chk(K_CPU, 1, "t5_cpu_reedge");
    rd(REG_PENDING, 0, "t5_no_extra_req"); tick();

    // Reset mid-service, then EOI in IDLE
    src_irq = '0; rst = 1'b1; tick(); rst = 1'b0;
    chk(K_CPU, 0, "rst2_cpu"); chk(K_ACT, 0, "rst2_active");
    rd(REG_PENDING, 0, "rst2_pending"); tick();
    rd(REG_MASK, 0, "rst2_mask"); tick();
    rd(REG_ACTIVE, 0, "rst2_active_reg"); tick();
    rd(REG_STATUS, 0, "rst2_status"); tick();
    wr(REG_ACTIVE, 0);
    rd(REG_STATUS, 0, "eoi_idle_status"); chk(K_CPU, 0, "eoi_idle_cpu"); tick();

    tick(); tick();
    if (q.size() > 0) begin
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      vectors     += q.size();
      miscompares += q.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
